uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, SHALL set sample_en ticks per bit (even, >=8).
REQ-002 Parameter PARITY_ODD, default 0, SHALL select even parity (0) or odd parity (1).
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 sample_en  input  1  oversample tick; SHALL be tied to 1 for one sample per clk.
REQ-006 rxd  input  1  asynchronous serial line; idles high.
REQ-007 rx_ready  input  1  consumer accepts the held byte.
REQ-008 rx_data  output  8  received byte, LSB first on the line.
REQ-009 rx_valid  output  1  rx_data and status valid; held until accepted.
REQ-010 parity_err  output  1  parity mismatch on the held byte; qualified by rx_valid.
REQ-011 frame_err  output  1  stop bit sampled low on the held byte; qualified by rx_valid.
REQ-012 overrun  output  1  one-cycle pulse when a byte is lost.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer before any use.
REQ-015 States SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-016 The sample counter cnt SHALL advance only on sample_en and SHALL clear on every state change.
REQ-017 IDLE: a synchronized low SHALL move to START with cnt=0; call this edge T.
REQ-018 START: at cnt==OVERSAMPLE/2-1, a low sample SHALL move to DATA; a high sample SHALL return to IDLE with no output (false start).
REQ-019 DATA/PARITY/STOP: each bit SHALL be decided at cnt==OVERSAMPLE-1.
REQ-020 DATA SHALL capture 8 bits LSB first, then move to PARITY.
REQ-021 PARITY: parity_err SHALL equal (XOR of data bits ^ parity bit) != PARITY_ODD.
REQ-022 STOP: the block SHALL latch rx_data, parity_err and frame_err and set rx_valid at the decision edge (T+8+10*OVERSAMPLE sample_en ticks).
REQ-023 STOP with stop sampled high SHALL go to IDLE; stop sampled low SHALL set frame_err and go to BREAK.
REQ-024 BREAK SHALL stay until the synchronized rxd is high, then go to IDLE.
REQ-025 rx_valid SHALL clear on the edge where rx_valid && rx_ready.
REQ-026 Handshake when a frame completes while rx_valid is high and rx_ready is low:
- new byte and status SHALL overwrite the held ones;
- overrun SHALL pulse for 1 cycle;
- rx_valid SHALL stay high.
REQ-027 Frame completion and acceptance on the same edge SHALL leave rx_valid high with the new byte and no overrun.
REQ-028 sample_en low SHALL freeze cnt and state but SHALL NOT stall the synchronizer or the handshake.

Reset
REQ-029 While reset is asserted:
- state SHALL be IDLE;
- cnt, rx_data, rx_valid, parity_err, frame_err, overrun and busy SHALL be 0;
- synchronizer flops SHALL be 1.
REQ-030 Reset mid-frame SHALL discard the partial byte; after release, the next start SHALL require a synchronized low in IDLE.

Configuration
REQ-031 With UART_RX_MAJORITY_EN defined, each DATA/PARITY/STOP decision SHALL be the 2-of-3 majority of the samples at cnt OVERSAMPLE-3, -2 and -1.
REQ-032 Without UART_RX_MAJORITY_EN, each decision SHALL use the single sample at cnt==OVERSAMPLE-1.
REQ-033 Start validation (REQ-018) SHALL be single-sample in both builds.

Structure
REQ-034 Shared package uart_pkg SHALL hold the RX state encodings, the default OVERSAMPLE and the parity-sense constants, shared with the TX side.
REQ-035 Sub-module uart_rx_sync SHALL contain the 2-flop synchronizer and the 3-sample majority shift register.

Verification
REQ-036 Bench settings: OVERSAMPLE=16, sample_en=1, even parity.
REQ-037 Frame 0xA5 with parity 0 and stop 1 -> rx_valid at T+168 with rx_data=0xA5, parity_err=0, frame_err=0.
REQ-038 Frame 0x01 with parity 0 -> rx_data=0x01 with parity_err=1.
REQ-039 Low glitch of 4 clk on an idle line -> START then back to IDLE; no rx_valid.
REQ-040 Line held low for 300 clk -> rx_data=0x00, frame_err=1, state BREAK until rxd rises; the next valid frame 0x3C is received cleanly.
REQ-041 Two frames 0x11 then 0x22 with rx_ready=0 -> overrun pulses once, rx_data=0x22; rx_ready=1 then clears rx_valid.
REQ-042 reset at T+80 of a frame -> all outputs 0, busy=0; the following frame 0x5A is received correctly.
REQ-043 UART_RX_MAJORITY_EN build: data bit 0 sample at cnt 15 inverted (single-sample glitch) -> byte still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART shared definitions: RX state encodings, default oversample, parity sense
package uart_pkg;

    // Receiver states; the TX side reuses the oversample and parity constants.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_t;

    localparam int UART_OVERSAMPLE_DEFAULT = 16;

    localparam bit UART_PARITY_EVEN = 1'b0;
    localparam bit UART_PARITY_ODD  = 1'b1;

    // 2-of-3 vote used to reject a single corrupted sample.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - rxd 2-flop synchronizer plus 3-sample majority history
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter bit MAJORITY_EN = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sample_en,
    input  logic i_rxd,
    output logic o_rxd_sync,
    output logic o_rxd_bit
);

    logic       r_sync1;
    logic       r_sync2;
    logic [1:0] r_hist;

    // Two-stage metastability guard; runs every clk regardless of sample_en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Keeps the two previous oversample ticks so the decision tick can vote with them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= 2'b11;
        end else if (i_sample_en) begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    assign o_rxd_sync = r_sync2;
    assign o_rxd_bit  = MAJORITY_EN ? majority3(r_sync2, r_hist[0], r_hist[1]) : r_sync2;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver (8 data, parity, 1 stop); UART_RX_MAJORITY_EN selects 2-of-3 bit voting
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter bit PARITY_ODD = UART_PARITY_EVEN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic       rxd,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_EN
    localparam bit MAJ_EN = 1'b1;
`else
    localparam bit MAJ_EN = 1'b0;
`endif

    logic            w_rxd_sync;
    logic            w_bit;

    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_perr;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_parity_err;
    logic            r_frame_err;
    logic            r_overrun;

    uart_rx_sync #(
        .MAJORITY_EN (MAJ_EN)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .i_sample_en (sample_en),
        .i_rxd       (rxd),
        .o_rxd_sync  (w_rxd_sync),
        .o_rxd_bit   (w_bit)
    );

    // Frame FSM plus output handshake; the handshake runs every clk, the FSM only on sample ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end

            if (sample_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rxd_sync) begin
                            r_state <= ST_START;
                            r_cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_cnt == C_HALF) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= w_rxd_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= '0;
                            r_shift <= {w_bit, r_shift[7:1]};
                            if (r_bit_idx == 3'd7) begin
                                r_state <= ST_PARITY;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (r_cnt == C_LAST) begin
                            r_cnt   <= '0;
                            r_perr  <= ((^r_shift) ^ w_bit) != PARITY_ODD;
                            r_state <= ST_STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_cnt == C_LAST) begin
                            r_cnt        <= '0;
                            r_rx_data    <= r_shift;
                            r_parity_err <= r_perr;
                            r_frame_err  <= !w_bit;
                            r_rx_valid   <= 1'b1;
                            if (r_rx_valid && !rx_ready) begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= w_bit ? ST_IDLE : ST_BREAK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        if (w_rxd_sync) begin
                            r_cnt   <= '0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_data    = r_rx_data;
    assign rx_valid   = r_rx_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (OVERSAMPLE=16, even parity)
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk;
    logic       reset;
    logic       sample_en;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int vectors;
    int miscompares;
    int valid_step;
    int ovr_seen;

    uart_rx #(
        .OVERSAMPLE (16),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .rxd        (rxd),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {stop, parity, data[7:0], start}
    function automatic logic [10:0] mk(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Drives one frame, 16 clk per bit, starting at the current negedge (step 0).
    task automatic send_frame(input logic [10:0] fr, input int ready_at,
                              input int abort_at, input int glitch_at);
        int   step;
        logic prev_v;
        step       = 0;
        valid_step = -1;
        ovr_seen   = 0;
        prev_v     = rx_valid;
        for (int b = 0; b < 11; b++) begin
            for (int k = 0; k < 16; k++) begin
                if (step == abort_at) begin
                    rxd = 1'b1;
                    return;
                end
                rxd = fr[b] ^ (step == glitch_at);
                if (step == ready_at) rx_ready = 1'b1;
                else if (step == ready_at + 1) rx_ready = 1'b0;
                @(negedge clk);
                step++;
                if (rx_valid && !prev_v && valid_step < 0) valid_step = step;
                if (overrun) ovr_seen++;
                prev_v = rx_valid;
            end
        end
    endtask

    task automatic accept(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk(tag, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        sample_en   = 1'b1;
        rxd         = 1'b1;
        rx_ready    = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_valid",  32'(rx_valid),   32'd0);
        chk("rst_busy",   32'(busy),       32'd0);
        chk("rst_data",   32'(rx_data),    32'h00);
        chk("rst_ovr",    32'(overrun),    32'd0);
        chk("rst_ferr",   32'(frame_err),  32'd0);
        chk("rst_sync",   32'(dut.u_sync.r_sync2), 32'd1);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Clean frame 0xA5: rx_valid first seen after edge T+168 = drive edge + 171
        send_frame(mk(8'hA5, 1'b0, 1'b1), -1, -1, -1);
        chk("a5_latency", 32'(valid_step), 32'd171);
        chk("a5_data",    32'(rx_data),    32'hA5);
        chk("a5_perr",    32'(parity_err), 32'd0);
        chk("a5_ferr",    32'(frame_err),  32'd0);
        chk("a5_busy",    32'(busy),       32'd0);
        accept("a5_accept");

        // 0x01 with parity 0 under even parity -> parity error
        send_frame(mk(8'h01, 1'b0, 1'b1), -1, -1, -1);
        chk("p01_data",  32'(rx_data),    32'h01);
        chk("p01_perr",  32'(parity_err), 32'd1);
        chk("p01_valid", 32'(rx_valid),   32'd1);

        // Reset at T+80 (step 83) of frame 0x5A while 0x01 is still held
        send_frame(mk(8'h5A, 1'b0, 1'b1), -1, 83, -1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rx_valid),   32'd0);
        chk("mid_rst_busy",  32'(busy),       32'd0);
        chk("mid_rst_data",  32'(rx_data),    32'h00);
        chk("mid_rst_perr",  32'(parity_err), 32'd0);
        chk("mid_rst_ferr",  32'(frame_err),  32'd0);
        chk("mid_rst_ovr",   32'(overrun),    32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'd0);
        send_frame(mk(8'h5A, 1'b0, 1'b1), -1, -1, -1);
        chk("r5a_latency", 32'(valid_step), 32'd171);
        chk("r5a_data",    32'(rx_data),    32'h5A);
        chk("r5a_perr",    32'(parity_err), 32'd0);
        accept("r5a_accept");

        // 4-clk low glitch: START entered at drive+3, rejected at drive+11
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        @(negedge clk);
        chk("glitch_start", 32'(dut.r_state), 32'(ST_START));
        chk("glitch_busy",  32'(busy),        32'd1);
        repeat (15) @(negedge clk);
        chk("glitch_idle",  32'(busy),        32'd0);
        chk("glitch_novld", 32'(rx_valid),    32'd0);

        // Back-to-back frames with no acceptance -> single overrun, newest byte held
        send_frame(mk(8'h11, 1'b0, 1'b1), -1, -1, -1);
        chk("ov1_ovr",   32'(ovr_seen), 32'd0);
        send_frame(mk(8'h22, 1'b0, 1'b1), -1, -1, -1);
        chk("ov2_ovr",   32'(ovr_seen), 32'd1);
        chk("ov2_data",  32'(rx_data),  32'h22);
        chk("ov2_valid", 32'(rx_valid), 32'd1);

        // Completion and acceptance on the same edge: valid stays, no overrun
        send_frame(mk(8'h66, 1'b0, 1'b1), 170, -1, -1);
        chk("same_ovr",   32'(ovr_seen), 32'd0);
        chk("same_data",  32'(rx_data),  32'h66);
        chk("same_valid", 32'(rx_valid), 32'd1);
        accept("same_accept");

        // Line held low 300 clk -> 0x00 with frame error, BREAK until line rises
        rxd = 1'b0;
        for (int s = 1; s <= 300; s++) begin
            @(negedge clk);
            if (s == 200) begin
                chk("brk_state", 32'(dut.r_state), 32'(ST_BREAK));
                chk("brk_busy",  32'(busy),        32'd1);
                chk("brk_valid", 32'(rx_valid),    32'd1);
                chk("brk_data",  32'(rx_data),     32'h00);
                chk("brk_ferr",  32'(frame_err),   32'd1);
                chk("brk_perr",  32'(parity_err),  32'd0);
            end
        end
        chk("brk_hold", 32'(busy), 32'd1);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        chk("brk_exit", 32'(busy), 32'd0);
        accept("brk_accept");
        send_frame(mk(8'h3C, 1'b0, 1'b1), -1, -1, -1);
        chk("c3c_latency", 32'(valid_step), 32'd171);
        chk("c3c_data",    32'(rx_data),    32'h3C);
        chk("c3c_perr",    32'(parity_err), 32'd0);
        chk("c3c_ferr",    32'(frame_err),  32'd0);
        accept("c3c_accept");

`ifdef UART_RX_MAJORITY_EN
        // Invert only the cnt-15 sample of data bit 0; the vote must outvote it
        send_frame(mk(8'hA5, 1'b0, 1'b1), -1, -1, 24);
        chk("maj_data", 32'(rx_data),    32'hA5);
        chk("maj_perr", 32'(parity_err), 32'd0);
        accept("maj_accept");
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
